mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM pipeline stage. Sits between the EX/MEM register and the MEM/WB register; its mem_* outputs feed MEM/WB directly.
- Runs load/store transactions on a req/ack data bus. Formats load data (byte/half extension, lane select) and raises stallreq to the pipeline controller while a bus access is outstanding.
- Non-memory instructions pass through combinationally with zero latency.

Parameters:
- DBUS_TIMEOUT, 255: maximum WAIT cycles before the access is abandoned and bus_err is pulsed; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  6  pipeline stall vector; stall[4]==1 means MEM/WB holds
- debug_pc_i  in  32  PC of the instruction in MEM
- debug_pc_o  out  32  PC passed on to MEM/WB
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_wdata  in  32  ALU result, used for non-loads
- mem_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 8=SB, 9=SH, 10=SW; all other codes are treated as none
- mem_addr  in  32  effective address
- mem_sdata  in  32  store source register value
- mem_waddr  out  5  to MEM/WB
- mem_we  out  1  to MEM/WB
- mem_wdata  out  32  to MEM/WB
- stallreq  out  1  to controller; 1 means stall IF..MEM
- addr_err  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on timeout
- dbus_req  out  1  bus request
- dbus_we  out  1  1=store
- dbus_sel  out  4  byte enables, lane i = bits[8i+7:8i]
- dbus_addr  out  32  word address, mem_addr with [1:0] cleared
- dbus_wdata  out  32  store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  transfer complete; sampled only while dbus_req=1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rdata_q=0, timeout counter=0.
  - All outputs 0 while rst=1, including mem_* outputs, debug_pc_o, dbus_*, stallreq and both error pulses.
- Alignment and access validity:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access issues no bus request, forces mem_we=0 and pulses addr_err for 1 cycle. The stage does not stall.
  - An aligned access with mem_op!=none is a "mem access".
- Byte enables (little-endian, lane = addr[1:0]):
  - Byte access: sel = 0001 shifted left by lane.
  - Halfword access: sel = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - Word access: sel = 1111.
- Store data: SB replicates sdata[7:0] to all 4 lanes; SH replicates sdata[15:0] to both halves; SW uses sdata unchanged.
- FSM states:
  - IDLE:
    - On a mem access: dbus_req=1 combinationally in this same cycle, stallreq=1.
    - If dbus_ack=1 in the same cycle: capture rdata_q, go to DONE. Otherwise go to WAIT.
  - WAIT:
    - dbus_req=1, stallreq=1; address, sel, we and data held from the unchanged (stalled) inputs; counter increments each cycle.
    - On ack: capture rdata_q, go to DONE.
    - On counter==DBUS_TIMEOUT (when nonzero): pulse bus_err, drop req, go to DONE with rdata_q=0.
  - DONE:
    - dbus_req=0, stallreq=0; mem_* outputs present the result.
    - Go to IDLE when stall[4]==0 (MEM/WB has captured). Otherwise hold in DONE, holding rdata_q.
- Outputs:
  - mem_waddr = ex_waddr and debug_pc_o = debug_pc_i, both combinational.
  - mem_we for loads = ex_we only in DONE, 0 otherwise.
  - mem_we for stores and non-memory ops = ex_we.
  - mem_wdata for a load in DONE, with b = byte of rdata_q at lane addr[1:0] and h = half at addr[1]:
    - LB = sign-extended b; LBU = zero-extended b.
    - LH = sign-extended h; LHU = zero-extended h.
    - LW = rdata_q.
  - mem_wdata for everything else = ex_wdata.
- Boundary rules:
  - The counter clears on every entry to WAIT.
  - A dbus_ack with dbus_req=0 is ignored.
  - Asserting rst in WAIT abandons the transaction immediately; the bus must tolerate a dropped req.
  - Back-to-back mem accesses: the second starts in IDLE on the cycle after DONE exits.

Test Plan:
- ALU op, mem_op=0, ex_wdata=0x12345678, waddr=5, we=1 -> same cycle mem_wdata=0x12345678, mem_waddr=5, mem_we=1, stallreq=0, dbus_req=0.
- LB at addr 0x1003, ack after 2 cycles with rdata=0x80AABBCC -> stallreq=1 for 3 cycles, sel=1000, dbus_addr=0x1000; in DONE mem_wdata=0xFFFFFF80, mem_we=1.
- SH at addr 0x2002, sdata=0xDEAD1234, zero-wait ack -> same-cycle dbus_we=1, sel=1100, wdata=0x12341234; DONE next cycle; stallreq high 1 cycle.
- LW at addr 0x3001 -> addr_err pulses 1 cycle, dbus_req stays 0, mem_we=0, no stall.
- LHU at 0x4002 acked with rdata=0xBEEF0000 while stall[4]=1 for 3 cycles -> DONE held, mem_wdata=0x0000BEEF stable; IDLE after stall[4] drops.
- LW with no ack, DBUS_TIMEOUT=4 -> bus_err pulses once, req drops, mem_wdata=0; separately, rst asserted mid-WAIT -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: runs load/store transfers on a req/ack data bus,
// formats load data and holds the pipeline while a bus access is in flight.
// Non-memory instructions pass straight through without any latency.
module mem_access #(
  parameter int DBUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [31:0] debug_pc_i,
  output logic [31:0] debug_pc_o,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_we,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam int CW = (DBUS_TIMEOUT > 1) ? $clog2(DBUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(DBUS_TIMEOUT);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;

  logic        is_load;
  logic        is_store;
  logic        sz_byte;
  logic        sz_half;
  logic        sz_word;
  logic        misaligned;
  logic        access;
  logic        timeout_hit;
  logic        req_int;
  logic [3:0]  sel_int;
  logic [31:0] sdata_int;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Only stall[4] (MEM/WB hold) matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Decode the memory opcode into direction and access size; unknown codes act as no-op.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      default:       ;
    endcase
  end

  assign misaligned  = (sz_half & mem_addr[0]) | (sz_word & (mem_addr[1:0] != 2'b00));
  assign access      = (is_load | is_store) & ~misaligned;
  assign timeout_hit = (DBUS_TIMEOUT != 0) && (state == WAIT) && (cnt == TIMEOUT_VAL);
  assign req_int     = ((state == IDLE) && access) || ((state == WAIT) && !timeout_hit);

  // Byte enables and lane-replicated store data for the current access size.
  always_comb begin
    sel_int   = 4'b0000;
    sdata_int = mem_sdata;
    if (sz_byte) begin
      sel_int   = 4'b0001 << mem_addr[1:0];
      sdata_int = {4{mem_sdata[7:0]}};
    end else if (sz_half) begin
      sel_int   = mem_addr[1] ? 4'b1100 : 4'b0011;
      sdata_int = {2{mem_sdata[15:0]}};
    end else if (sz_word) begin
      sel_int   = 4'b1111;
    end
  end

  // Pick the addressed byte/half from the captured word and extend it for the load type.
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mem_op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  // Bus transaction sequencer: start in IDLE, wait for ack or timeout, then hold the result until MEM/WB takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'd0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (dbus_ack) begin
              rdata_q <= dbus_rdata;
              state   <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (timeout_hit) begin
            rdata_q <= 32'd0;
            state   <= DONE;
          end else if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!stall[4]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drive the pipeline and bus outputs; everything reads zero while reset is held.
  always_comb begin
    debug_pc_o = 32'd0;
    mem_waddr  = 5'd0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    stallreq   = 1'b0;
    addr_err   = 1'b0;
    bus_err    = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_sel   = 4'b0000;
    dbus_addr  = 32'd0;
    dbus_wdata = 32'd0;
    if (!rst) begin
      debug_pc_o = debug_pc_i;
      mem_waddr  = ex_waddr;
      mem_we     = is_load ? ((state == DONE) & ex_we) : ex_we;
      if ((is_load | is_store) & misaligned) begin
        mem_we = 1'b0;
      end
      mem_wdata  = (is_load && state == DONE) ? ld_data : ex_wdata;
      stallreq   = ((state == IDLE) && access) || (state == WAIT);
      addr_err   = (state == IDLE) && (is_load | is_store) && misaligned;
      bus_err    = timeout_hit;
      dbus_req   = req_int;
      if (req_int) begin
        dbus_we    = is_store;
        dbus_sel   = sel_int;
        dbus_addr  = {mem_addr[31:2], 2'b00};
        dbus_wdata = is_store ? sdata_int : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access: a bus responder with random ack latency and
// a reference model working from access size and address arithmetic.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] debug_pc_i;
  logic [31:0] debug_pc_o;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        addr_err;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  int checks = 0;
  int errors = 0;

  mem_access #(.DBUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .debug_pc_i(debug_pc_i), .debug_pc_o(debug_pc_o),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .addr_err(addr_err), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  // Safety net in case the clock or a task ever stalls the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                               input logic [31:0] pc);
    mem_op     = op;
    mem_addr   = addr;
    mem_sdata  = sdata;
    ex_waddr   = waddr;
    ex_we      = we;
    ex_wdata   = wdata;
    debug_pc_i = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes, 0 for anything that is not a load or store.
  function automatic int accSize(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8: return 1;
      4'd3, 4'd4, 4'd9: return 2;
      4'd5, 4'd10:      return 4;
      default:          return 0;
    endcase
  endfunction

  // Reference load result from plain shifts and two's-complement arithmetic.
  function automatic logic [31:0] loadResult(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  // One instruction through the stage; delay > TO means the bus never answers.
  task automatic runTxn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int delay, input int hold,
                        input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                        input logic [31:0] pc);
    int          sz;
    bit          ld;
    bit          st;
    bit          mis;
    bit          timedOut;
    int          last;
    logic [31:0] expSel;
    logic [31:0] expData;
    logic [31:0] expLoad;
    sz  = accSize(op);
    ld  = (op >= 4'd1 && op <= 4'd5);
    st  = (op >= 4'd8 && op <= 4'd10);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    applyStimulus(op, addr, sdata, waddr, we, wdata, pc);
    stall = 6'd0;
    if (!(ld || st) || mis) begin
      dbus_ack   = 1'($urandom_range(0, 1));
      dbus_rdata = $urandom;
      @(negedge clk);
      checkOutput("pass_wdata", mem_wdata, wdata);
      checkOutput("pass_waddr", 32'(mem_waddr), 32'(waddr));
      checkOutput("pass_pc", debug_pc_o, pc);
      checkOutput("pass_we", 32'(mem_we), mis ? 32'd0 : 32'(we));
      checkOutput("pass_stallreq", 32'(stallreq), 32'd0);
      checkOutput("pass_req", 32'(dbus_req), 32'd0);
      checkOutput("addr_err", 32'(addr_err), mis ? 32'd1 : 32'd0);
      tick();
      dbus_ack = 1'b0;
      return;
    end
    if (sz == 1)      expSel = 32'd1 << (addr % 4);
    else if (sz == 2) expSel = 32'd3 << (addr % 4);
    else              expSel = 32'd15;
    if (sz == 1)      expData = (sdata % 256) * 32'h01010101;
    else if (sz == 2) expData = (sdata % 65536) * 32'h00010001;
    else              expData = sdata;
    timedOut = (delay > TO);
    last     = timedOut ? TO + 1 : delay;
    for (int c = 0; c <= last; c++) begin
      dbus_ack   = (c == delay);
      dbus_rdata = (c == delay) ? rdata : $urandom;
      @(negedge clk);
      checkOutput("busy_stallreq", 32'(stallreq), 32'd1);
      checkOutput("busy_mem_we", 32'(mem_we), ld ? 32'd0 : 32'(we));
      if (timedOut && c == last) begin
        checkOutput("timeout_req", 32'(dbus_req), 32'd0);
        checkOutput("timeout_bus_err", 32'(bus_err), 32'd1);
      end else begin
        checkOutput("busy_req", 32'(dbus_req), 32'd1);
        checkOutput("busy_bus_err", 32'(bus_err), 32'd0);
        checkOutput("busy_sel", 32'(dbus_sel), expSel);
        checkOutput("busy_addr", dbus_addr, addr - (addr % 4));
        checkOutput("busy_we", 32'(dbus_we), st ? 32'd1 : 32'd0);
        if (st) checkOutput("busy_wdata", dbus_wdata, expData);
      end
      tick();
    end
    dbus_ack = 1'b0;
    expLoad  = loadResult(op, addr, timedOut ? 32'd0 : rdata);
    for (int h = 0; h <= hold; h++) begin
      stall = (h < hold) ? 6'b010000 : 6'b000000;
      @(negedge clk);
      checkOutput("done_stallreq", 32'(stallreq), 32'd0);
      checkOutput("done_req", 32'(dbus_req), 32'd0);
      checkOutput("done_bus_err", 32'(bus_err), 32'd0);
      checkOutput("done_mem_we", 32'(mem_we), 32'(we));
      checkOutput("done_wdata", mem_wdata, ld ? expLoad : wdata);
      tick();
    end
    stall = 6'd0;
  endtask

  initial begin
    logic [3:0]  opList [10];
    logic [3:0]  op;
    logic [31:0] addr;
    int          sz;
    int          delay;
    opList = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd7};

    rst        = 1'b1;
    stall      = 6'd0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'd0;
    applyStimulus(4'd0, 32'h0000_1234, 32'h1111_2222, 5'd7, 1'b1, 32'hCAFE_F00D, 32'h0000_0400);
    #3;
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_pc", debug_pc_o, 32'd0);
    checkOutput("rst_req", 32'(dbus_req), 32'd0);
    tick();
    rst = 1'b0;

    // Directed cases from the plan.
    runTxn(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd5, 1'b1, 32'h12345678, 32'h100);
    runTxn(4'd1, 32'h1003, 32'h0, 32'h80AABBCC, 2, 0, 5'd3, 1'b1, 32'h0, 32'h104);
    runTxn(4'd9, 32'h2002, 32'hDEAD1234, 32'h0, 0, 0, 5'd0, 1'b0, 32'h55, 32'h108);
    runTxn(4'd5, 32'h3001, 32'h0, 32'h0, 0, 0, 5'd9, 1'b1, 32'h77, 32'h10C);
    runTxn(4'd4, 32'h4002, 32'h0, 32'hBEEF0000, 0, 3, 5'd4, 1'b1, 32'h0, 32'h110);
    runTxn(4'd5, 32'h5000, 32'h0, 32'hFFFFFFFF, TO + 5, 0, 5'd6, 1'b1, 32'h0, 32'h114);

    // Reset in the middle of a bus wait abandons it immediately.
    applyStimulus(4'd5, 32'h6000, 32'h0, 5'd8, 1'b1, 32'h1234, 32'h118);
    dbus_ack = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(dbus_req), 32'd0);
    checkOutput("midrst_stallreq", 32'(stallreq), 32'd0);
    checkOutput("midrst_addr", dbus_addr, 32'd0);
    checkOutput("midrst_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_wdata", mem_wdata, 32'd0);
    tick();
    rst = 1'b0;
    runTxn(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd2, 1'b1, 32'hA5A5A5A5, 32'h11C);

    // Random mix; most accesses aligned, occasional timeouts.
    for (int n = 0; n < 60; n++) begin
      op   = opList[$urandom_range(0, 9)];
      addr = $urandom;
      sz   = accSize(op);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 4) addr[1:0] = 2'b00;
        else if (sz == 2) addr[0] = 1'b0;
      end
      delay = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 3));
      runTxn(op, addr, $urandom, $urandom, delay, int'($urandom_range(0, 2)),
             5'($urandom), 1'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
